lcd_backlight_pwm_gen: RTL and testbench

Consumes the 8-bit backlight duty value written by the NiosII into the LCD backlight PIO register and drives the LCD backlight enable pin with a glitch-free PWM waveform. Contains a clock prescaler, a 255-step PWM counter, and a period-synchronous duty register. An optional linear ramp fades the applied duty toward the requested value. Sits directly between the PIO out_port and the top-level LCD_BL pin.

---
 rtl/lcd_backlight_pwm_gen.sv | 131 +++++++++++++
 tb/tb_lcd_backlight_pwm_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_backlight_pwm_gen.sv
// lcd_backlight_pwm_gen
// Converts the 8-bit backlight duty written by the CPU into a glitch-free PWM
// waveform for the LCD backlight enable pin. A prescaler divides clk into PWM
// count steps, a 255-step counter forms the period, and the requested duty is
// only sampled on a period boundary so a write never produces a runt pulse.
// An optional linear ramp walks the applied duty one step at a time toward the
// requested value, spending RAMP_PERIODS PWM periods on each step.
//
// Parameters
//   CLK_DIV       clk cycles per PWM count step (1..65535)
//   RAMP_PERIODS  PWM periods per +/-1 duty step; 0 applies the target at the
//                 next period boundary
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        1 = running; 0 = output low, counters and applied duty cleared
//   duty_in       requested duty (0 = off, 255 = always on)
//   pwm_out       registered PWM output
//   duty_cur      duty currently applied to the waveform
//   ramp_busy     high while the applied duty has not reached the target
//   period_start  one-clk pulse on the first clock of each PWM period
module lcd_backlight_pwm_gen #(
  parameter int unsigned CLK_DIV      = 196,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] duty_in,
  output logic       pwm_out,
  output logic [7:0] duty_cur,
  output logic       ramp_busy,
  output logic       period_start
);

  localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam int unsigned RAMP_LAST_I = (RAMP_PERIODS == 0) ? 0 : RAMP_PERIODS - 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST  = RAMP_W'(RAMP_LAST_I);
  localparam logic [7:0]         CNT_LAST   = 8'd254;

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt;
  logic [7:0]         cnt;
  logic [7:0]         cnt_nxt;
  logic [7:0]         target;
  logic [7:0]         target_nxt;
  logic [7:0]         duty_nxt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic [RAMP_W-1:0]  ramp_cnt_nxt;
  logic               tick_c;
  logic               bnd_c;

  // Count-step strobe and end-of-period event
  always_comb begin
    tick_c = (presc == PRESC_LAST);
    bnd_c  = tick_c && (cnt == CNT_LAST);
  end

  // Next-state for prescaler, PWM counter, target and ramp
  always_comb begin
    presc_nxt    = presc;
    cnt_nxt      = cnt;
    target_nxt   = target;
    duty_nxt     = duty_cur;
    ramp_cnt_nxt = ramp_cnt;

    // The target is sampled on every boundary, even one that coincides with
    // a disable, so the request is not lost across an enable toggle.
    if (bnd_c) begin
      target_nxt = duty_in;
    end

    if (!enable) begin
      presc_nxt    = '0;
      cnt_nxt      = '0;
      duty_nxt     = '0;
      ramp_cnt_nxt = '0;
    end else begin
      presc_nxt = tick_c ? '0 : presc + PRESC_W'(1);

      if (tick_c) begin
        cnt_nxt = (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
      end

      if (bnd_c) begin
        // Ramp decisions use the freshly sampled duty_in, not the old target
        if (RAMP_PERIODS == 0) begin
          duty_nxt = duty_in;
        end else if (duty_cur == duty_in) begin
          ramp_cnt_nxt = '0;
        end else if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt_nxt = '0;
          duty_nxt     = (duty_cur < duty_in) ? duty_cur + 8'd1 : duty_cur - 8'd1;
        end else begin
          ramp_cnt_nxt = ramp_cnt + RAMP_W'(1);
        end
      end else if (duty_cur == target) begin
        ramp_cnt_nxt = '0;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc        <= '0;
      cnt          <= '0;
      target       <= '0;
      duty_cur     <= '0;
      ramp_cnt     <= '0;
      pwm_out      <= 1'b0;
      ramp_busy    <= 1'b0;
      period_start <= 1'b0;
    end else begin
      presc        <= presc_nxt;
      cnt          <= cnt_nxt;
      target       <= target_nxt;
      duty_cur     <= duty_nxt;
      ramp_cnt     <= ramp_cnt_nxt;
      // cnt never reaches 255, so duty 255 keeps the output solidly high
      pwm_out      <= enable && (cnt < duty_cur);
      ramp_busy    <= (duty_cur != target);
      period_start <= enable && bnd_c;
    end
  end

endmodule

// File: tb/tb_lcd_backlight_pwm_gen.sv
// Testbench for lcd_backlight_pwm_gen: two instances (CLK_DIV=2 without ramp,
// CLK_DIV=1 with a 2-period ramp) share stimulus and are compared each cycle
// against a period-position model, plus directed checks on edge cases.
module tb_lcd_backlight_pwm_gen;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] duty_in = 8'd128;

  logic       a_pwm, a_busy, a_ps;
  logic [7:0] a_duty;
  logic       b_pwm, b_busy, b_ps;
  logic [7:0] b_duty;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lcd_backlight_pwm_gen #(.CLK_DIV(2), .RAMP_PERIODS(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(a_pwm), .duty_cur(a_duty), .ramp_busy(a_busy), .period_start(a_ps)
  );

  lcd_backlight_pwm_gen #(.CLK_DIV(1), .RAMP_PERIODS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .duty_in(duty_in),
    .pwm_out(b_pwm), .duty_cur(b_duty), .ramp_busy(b_busy), .period_start(b_ps)
  );

  // Reference model: position within the period in clk cycles, plus duty state
  typedef struct {
    int cdiv;
    int rper;
    int t;
    int target;
    int duty;
    int rcnt;
    bit pwm;
    bit ps;
    bit busy;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(mdl_t m);
    mdl_t n;
    n = m;
    n.t = 0; n.target = 0; n.duty = 0; n.rcnt = 0;
    n.pwm = 1'b0; n.ps = 1'b0; n.busy = 1'b0;
    return n;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit en, int din);
    mdl_t n;
    int   per;
    bit   last;
    n    = m;
    per  = 255 * m.cdiv;
    last = (m.t == per - 1);
    n.pwm  = en && ((m.t / m.cdiv) < m.duty);
    n.busy = (m.duty != m.target);
    n.ps   = en && last;
    if (last) n.target = din;
    if (!en) begin
      n.t = 0; n.duty = 0; n.rcnt = 0;
    end else begin
      n.t = (m.t + 1) % per;
      if (last) begin
        if (m.rper == 0) n.duty = din;
        else if (m.duty == din) n.rcnt = 0;
        else begin
          n.rcnt = m.rcnt + 1;
          if (n.rcnt == m.rper) begin
            n.rcnt = 0;
            n.duty = (din > m.duty) ? m.duty + 1 : m.duty - 1;
          end
        end
      end else if (m.duty == m.target) begin
        n.rcnt = 0;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    ma = mdl_step(ma, enable, int'(duty_in));
    mb = mdl_step(mb, enable, int'(duty_in));
    @(negedge clk);
    check("a_out", 32'({a_pwm, a_duty, a_busy, a_ps}),
          32'({ma.pwm, 8'(ma.duty), ma.busy, ma.ps}));
    check("b_out", 32'({b_pwm, b_duty, b_busy, b_ps}),
          32'({mb.pwm, 8'(mb.duty), mb.busy, mb.ps}));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_a", 32'({a_pwm, a_duty, a_busy, a_ps}), 32'd0);
    check("rst_b", 32'({b_pwm, b_duty, b_busy, b_ps}), 32'd0);
    ma = mdl_reset(ma);
    mb = mdl_reset(mb);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int first_ps;
    int hi;
    int lo;
    int waited;

    ma = '{cdiv: 2, rper: 0, default: 0};
    mb = '{cdiv: 1, rper: 2, default: 0};

    // Reset with enable high and a pending request
    #2 reset_n = 1'b0;
    #1;
    check("por_a", 32'({a_pwm, a_duty, a_busy, a_ps}), 32'd0);
    check("por_b", 32'({b_pwm, b_duty, b_busy, b_ps}), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // First boundary 255*CLK_DIV clocks after release
    first_ps = 0;
    for (int i = 1; i <= 600; i++) begin
      cycle();
      if (a_ps && first_ps == 0) begin
        first_ps = i;
        check("a_duty_at_bnd", 32'(a_duty), 32'd128);
      end
    end
    check("a_first_ps", 32'(first_ps), 32'd510);

    // Steady duty 128: high time per period
    waited = 0;
    while (!a_ps && waited < 2000) begin cycle(); waited++; end
    check("a_ps_found", 32'(a_ps), 32'd1);
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      cycle();
      if (i == 0) check("a_rise_after_ps", 32'(a_pwm), 32'd1);
      if (a_pwm) hi++;
    end
    check("a_high_128", 32'(hi), 32'd256);

    // Extremes: 255 never drops, 0 never rises
    duty_in = 8'd255;
    run(1020);
    lo = 0;
    for (int i = 0; i < 2550; i++) begin cycle(); if (!a_pwm) lo++; end
    check("a_low_255", 32'(lo), 32'd0);
    duty_in = 8'd0;
    run(1020);
    hi = 0;
    for (int i = 0; i < 2550; i++) begin cycle(); if (a_pwm) hi++; end
    check("a_high_0", 32'(hi), 32'd0);

    // Mid-period change 64 -> 200 on the 2-div instance
    duty_in = 8'd64;
    run(1020);
    waited = 0;
    while (!a_ps && waited < 2000) begin cycle(); waited++; end
    hi = 0;
    for (int i = 0; i < 510; i++) begin
      cycle();
      if (i == 200) duty_in = 8'd200;
      if (a_pwm) hi++;
    end
    check("a_high_64", 32'(hi), 32'd128);
    hi = 0;
    for (int i = 0; i < 510; i++) begin cycle(); if (a_pwm) hi++; end
    check("a_high_200", 32'(hi), 32'd400);

    // Ramp on the ramped instance: clear applied duty, then request 3
    duty_in = 8'd0;
    run(600);
    enable = 1'b0;
    run(3);
    check("b_dis_duty", 32'(b_duty), 32'd0);
    check("b_dis_pwm", 32'(b_pwm), 32'd0);
    enable = 1'b1;
    duty_in = 8'd3;
    run(2550);
    check("b_ramp_done", 32'(b_duty), 32'd3);
    check("b_ramp_idle", 32'(b_busy), 32'd0);

    // Reversal mid-ramp: at duty 2 request 1, next step goes down
    duty_in = 8'd0;
    run(600);
    enable = 1'b0;
    run(2);
    enable = 1'b1;
    duty_in = 8'd3;
    waited = 0;
    while (b_duty != 8'd2 && waited < 3000) begin cycle(); waited++; end
    check("b_reach_2", 32'(b_duty), 32'd2);
    check("b_busy_mid", 32'(b_busy), 32'd1);
    duty_in = 8'd1;
    waited = 0;
    while (b_duty == 8'd2 && waited < 1500) begin cycle(); waited++; end
    check("b_reverse", 32'(b_duty), 32'd1);

    // Randomized requests, enable drops and one mid-run reset
    for (int s = 0; s < 40; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      duty_in = 8'd0;
      else if (r == 1) duty_in = 8'd255;
      else             duty_in = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        enable = 1'b0;
        run(int'($urandom_range(1, 20)));
        enable = 1'b1;
      end
      if (s == 20) do_reset();
      run(int'($urandom_range(1, 700)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
